// File: rtl/decode_stage_pkg.sv
// Shared RV32I decode definitions: opcodes, funct encodings, ALU codes and the
// decoded control bundle passed from decode to execute.
package decode_stage_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned ALUCODE_W = 5;
    localparam int unsigned REG_W     = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [ALUCODE_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [ALUCODE_W-1:0] ALU_SUB  = 5'd1;
    localparam logic [ALUCODE_W-1:0] ALU_SLL  = 5'd2;
    localparam logic [ALUCODE_W-1:0] ALU_SLT  = 5'd3;
    localparam logic [ALUCODE_W-1:0] ALU_SLTU = 5'd4;
    localparam logic [ALUCODE_W-1:0] ALU_XOR  = 5'd5;
    localparam logic [ALUCODE_W-1:0] ALU_SRL  = 5'd6;
    localparam logic [ALUCODE_W-1:0] ALU_SRA  = 5'd7;
    localparam logic [ALUCODE_W-1:0] ALU_OR   = 5'd8;
    localparam logic [ALUCODE_W-1:0] ALU_AND  = 5'd9;
    localparam logic [ALUCODE_W-1:0] ALU_LUI  = 5'd10;

    typedef struct packed {
        logic [XLEN-1:0]      imm;
        logic [ALUCODE_W-1:0] alucode;
        logic                 using_r2;
        logic                 using_pc;
        logic [REG_W-1:0]     rs1;
        logic [REG_W-1:0]     rs2;
        logic [REG_W-1:0]     rd;
        logic                 reg_we;
        logic                 mem_re;
        logic                 mem_we;
        logic [2:0]           funct3;
        logic                 is_branch;
        logic                 is_jal;
        logic                 is_jalr;
        logic                 illegal;
    } dec_t;

    // Register-register / register-immediate ALU op from funct3 and the alternate bit.
    function automatic logic [ALUCODE_W-1:0] alu_op(input logic [2:0] f3, input logic alt);
        logic [ALUCODE_W-1:0] op;
        case (f3)
            F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     op = ALU_SLL;
            F3_SLT:     op = ALU_SLT;
            F3_SLTU:    op = ALU_SLTU;
            F3_XOR:     op = ALU_XOR;
            F3_SR:      op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:      op = ALU_OR;
            default:    op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic dec_t dec_reset();
        dec_t d;
        d         = '0;
        d.alucode = ALU_ADD;
        return d;
    endfunction

endpackage

// File: rtl/decode_stage_decode_logic.sv
// Combinational RV32I decoder: instruction word to execute control bundle.
module decode_logic
    import decode_stage_pkg::*;
(
    input  logic [31:0] inst_i,
    output dec_t        dec_o
);

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            legal;
    logic            we;
    dec_t            d;

    assign opcode = inst_i[6:0];
    assign f3     = inst_i[14:12];
    assign f7     = inst_i[31:25];

    assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u = {inst_i[31:12], 12'b0};
    assign imm_j = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    always_comb begin
        d         = '0;
        d.alucode = ALU_ADD;
        d.rs1     = inst_i[19:15];
        d.rs2     = inst_i[24:20];
        d.rd      = inst_i[11:7];
        d.funct3  = f3;
        legal     = 1'b1;
        we        = 1'b0;
        case (opcode)
            OPC_OP: begin
                d.alucode  = alu_op(f3, f7 == F7_ALT);
                d.using_r2 = 1'b1;
                we         = 1'b1;
                legal      = (f7 == F7_BASE) ||
                             ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SR)));
            end
            OPC_OP_IMM: begin
                d.alucode = alu_op(f3, (f3 == F3_SR) && (f7 == F7_ALT));
                we        = 1'b1;
                if ((f3 == F3_SLL) || (f3 == F3_SR)) begin
                    // Shift amount is zero-extended; upper bits are funct7.
                    d.imm = {27'b0, inst_i[24:20]};
                    legal = (f7 == F7_BASE) || ((f3 == F3_SR) && (f7 == F7_ALT));
                end else begin
                    d.imm = imm_i;
                end
            end
            OPC_LUI: begin
                d.alucode = ALU_LUI;
                d.imm     = imm_u;
                we        = 1'b1;
            end
            OPC_AUIPC: begin
                d.using_pc = 1'b1;
                d.imm      = imm_u;
                we         = 1'b1;
            end
            OPC_LOAD: begin
                d.imm    = imm_i;
                d.mem_re = 1'b1;
                we       = 1'b1;
                legal    = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                           (f3 == F3_LBU) || (f3 == F3_LHU);
            end
            OPC_STORE: begin
                d.imm    = imm_s;
                d.mem_we = 1'b1;
                legal    = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
            end
            OPC_BRANCH: begin
                d.using_pc  = 1'b1;
                d.imm       = imm_b;
                d.is_branch = 1'b1;
                legal       = (f3 == F3_BEQ) || (f3 == F3_BNE) || (f3 == F3_BLT) ||
                              (f3 == F3_BGE) || (f3 == F3_BLTU) || (f3 == F3_BGEU);
            end
            OPC_JAL: begin
                d.using_pc = 1'b1;
                d.imm      = imm_j;
                d.is_jal   = 1'b1;
                we         = 1'b1;
            end
            OPC_JALR: begin
                d.imm     = imm_i;
                d.is_jalr = 1'b1;
                we        = 1'b1;
                legal     = (f3 == F3_JALR);
            end
            default: legal = 1'b0;
        endcase
        // Illegal words still flow downstream but must have no side effects.
        if (!legal) begin
            d.illegal   = 1'b1;
            d.alucode   = ALU_ADD;
            d.mem_re    = 1'b0;
            d.mem_we    = 1'b0;
            d.is_branch = 1'b0;
            d.is_jal    = 1'b0;
            d.is_jalr   = 1'b0;
            we          = 1'b0;
        end
        d.reg_we = we && (d.rd != 5'd0);
    end

    assign dec_o = d;

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: RV32I decoder feeding a registered output slot backed
// by a one-entry skid register so downstream stalls never drop an instruction.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned XLEN = decode_stage_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_alucode,
    output logic            out_using_r2,
    output logic            out_using_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic            out_reg_we,
    output logic            out_mem_re,
    output logic            out_mem_we,
    output logic [2:0]      out_funct3,
    output logic            out_is_branch,
    output logic            out_is_jal,
    output logic            out_is_jalr,
    output logic            out_illegal
);

    dec_t            dec_c;
    dec_t            out_dec_q, out_dec_d, skid_dec_q, skid_dec_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d, skid_pc_q, skid_pc_d;
    logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic            in_ready_q;
    logic            accept, primary_free;

    decode_logic u_decode_logic (
        .inst_i (in_inst),
        .dec_o  (dec_c)
    );

    assign accept       = in_valid && in_ready_q;
    assign primary_free = !out_valid_q || out_ready;

    // Slot steering: skid drains first, flush kills everything held.
    always_comb begin
        out_dec_d    = out_dec_q;
        out_pc_d     = out_pc_q;
        out_valid_d  = out_valid_q;
        skid_dec_d   = skid_dec_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (primary_free) begin
            if (skid_valid_q) begin
                out_dec_d    = skid_dec_q;
                out_pc_d     = skid_pc_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_dec_d   = dec_c;
                out_pc_d    = in_pc;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_dec_d   = dec_c;
            skid_pc_d    = in_pc;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_dec_q    <= dec_reset();
            out_pc_q     <= '0;
            out_valid_q  <= 1'b0;
            skid_dec_q   <= dec_reset();
            skid_pc_q    <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_dec_q    <= out_dec_d;
            out_pc_q     <= out_pc_d;
            out_valid_q  <= out_valid_d;
            skid_dec_q   <= skid_dec_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign out_pc        = out_pc_q;
    assign out_imm       = out_dec_q.imm;
    assign out_alucode   = out_dec_q.alucode;
    assign out_using_r2  = out_dec_q.using_r2;
    assign out_using_pc  = out_dec_q.using_pc;
    assign out_rs1       = out_dec_q.rs1;
    assign out_rs2       = out_dec_q.rs2;
    assign out_rd        = out_dec_q.rd;
    assign out_reg_we    = out_dec_q.reg_we;
    assign out_mem_re    = out_dec_q.mem_re;
    assign out_mem_we    = out_dec_q.mem_we;
    assign out_funct3    = out_dec_q.funct3;
    assign out_is_branch = out_dec_q.is_branch;
    assign out_is_jal    = out_dec_q.is_jal;
    assign out_is_jalr   = out_dec_q.is_jalr;
    assign out_illegal   = out_dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode vectors, skid backpressure, flush, async reset.
module tb_decode_stage;

    localparam logic [4:0] E_ADD = 5'd0;
    localparam logic [4:0] E_SUB = 5'd1;
    localparam logic [4:0] E_SRA = 5'd7;
    localparam logic [4:0] E_LUI = 5'd10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [4:0]  out_alucode;
    logic        out_using_r2;
    logic        out_using_pc;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_reg_we;
    logic        out_mem_re;
    logic        out_mem_we;
    logic [2:0]  out_funct3;
    logic        out_is_branch;
    logic        out_is_jal;
    logic        out_is_jalr;
    logic        out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_inst       (in_inst),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_imm       (out_imm),
        .out_alucode   (out_alucode),
        .out_using_r2  (out_using_r2),
        .out_using_pc  (out_using_pc),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_rd        (out_rd),
        .out_reg_we    (out_reg_we),
        .out_mem_re    (out_mem_re),
        .out_mem_we    (out_mem_we),
        .out_funct3    (out_funct3),
        .out_is_branch (out_is_branch),
        .out_is_jal    (out_is_jal),
        .out_is_jalr   (out_is_jalr),
        .out_illegal   (out_illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle offer; caller guarantees in_ready is high.
    task automatic issue(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = 32'h0;
        in_pc     = 32'h0;
        out_ready = 1'b1;
        #12;
        check("rst_valid",   32'(out_valid), 32'd0);
        check("rst_ready",   32'(in_ready), 32'd1);
        check("rst_alucode", 32'(out_alucode), 32'(E_ADD));
        check("rst_imm",     out_imm, 32'h0);
        check("rst_pc",      out_pc, 32'h0);
        rst_n = 1'b1;
        tick();

        // ADDI x1,x0,5
        issue(32'h00500093, 32'h0000_0010);
        check("addi_valid",   32'(out_valid), 32'd1);
        check("addi_alucode", 32'(out_alucode), 32'(E_ADD));
        check("addi_r2",      32'(out_using_r2), 32'd0);
        check("addi_pcsel",   32'(out_using_pc), 32'd0);
        check("addi_imm",     out_imm, 32'h0000_0005);
        check("addi_rd",      32'(out_rd), 32'd1);
        check("addi_rs1",     32'(out_rs1), 32'd0);
        check("addi_we",      32'(out_reg_we), 32'd1);
        check("addi_pc",      out_pc, 32'h0000_0010);

        // SRAI x2,x1,3 and its bad-funct7 twin
        issue(32'h4030D113, 32'h0000_0014);
        check("srai_alucode", 32'(out_alucode), 32'(E_SRA));
        check("srai_imm",     out_imm, 32'h0000_0003);
        check("srai_ill",     32'(out_illegal), 32'd0);
        issue(32'h2030D113, 32'h0000_0018);
        check("srai_bad_ill", 32'(out_illegal), 32'd1);
        check("srai_bad_we",  32'(out_reg_we), 32'd0);
        check("srai_bad_vld", 32'(out_valid), 32'd1);

        // LUI x5,0x12345
        issue(32'h123452B7, 32'h0000_001C);
        check("lui_alucode", 32'(out_alucode), 32'(E_LUI));
        check("lui_imm",     out_imm, 32'h1234_5000);
        check("lui_rd",      32'(out_rd), 32'd5);

        // BEQ x1,x2,-4 at pc 0x100
        issue(32'hFE208EE3, 32'h0000_0100);
        check("beq_alucode", 32'(out_alucode), 32'(E_ADD));
        check("beq_pcsel",   32'(out_using_pc), 32'd1);
        check("beq_imm",     out_imm, 32'hFFFF_FFFC);
        check("beq_br",      32'(out_is_branch), 32'd1);
        check("beq_rs1",     32'(out_rs1), 32'd1);
        check("beq_rs2",     32'(out_rs2), 32'd2);
        check("beq_we",      32'(out_reg_we), 32'd0);
        check("beq_pc",      out_pc, 32'h0000_0100);

        // SW x2,8(x1)
        issue(32'h0020A423, 32'h0000_0104);
        check("sw_memwe", 32'(out_mem_we), 32'd1);
        check("sw_memre", 32'(out_mem_re), 32'd0);
        check("sw_we",    32'(out_reg_we), 32'd0);
        check("sw_imm",   out_imm, 32'h0000_0008);
        check("sw_f3",    32'(out_funct3), 32'd2);

        // SUB x3,x1,x2
        issue(32'h402081B3, 32'h0000_0108);
        check("sub_alucode", 32'(out_alucode), 32'(E_SUB));
        check("sub_r2",      32'(out_using_r2), 32'd1);
        check("sub_we",      32'(out_reg_we), 32'd1);
        tick();
        check("idle_valid", 32'(out_valid), 32'd0);

        // Backpressure: three ADDIs (imm 1,2,3), downstream stalled from the first
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h00100093;
        in_pc     = 32'h0000_0200;
        tick();
        check("bp1_valid", 32'(out_valid), 32'd1);
        check("bp1_pc",    out_pc, 32'h0000_0200);
        check("bp1_ready", 32'(in_ready), 32'd1);
        in_inst = 32'h00200093;
        in_pc   = 32'h0000_0204;
        tick();
        check("bp2_ready", 32'(in_ready), 32'd0);
        check("bp2_pc",    out_pc, 32'h0000_0200);
        in_inst = 32'h00300093;
        in_pc   = 32'h0000_0208;
        tick();
        check("bp3_ready", 32'(in_ready), 32'd0);
        check("bp3_pc",    out_pc, 32'h0000_0200);
        check("bp3_imm",   out_imm, 32'h0000_0001);
        out_ready = 1'b1;
        tick();
        check("bp4_valid", 32'(out_valid), 32'd1);
        check("bp4_pc",    out_pc, 32'h0000_0204);
        check("bp4_imm",   out_imm, 32'h0000_0002);
        check("bp4_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp5_pc",    out_pc, 32'h0000_0208);
        check("bp5_imm",   out_imm, 32'h0000_0003);
        in_valid = 1'b0;
        tick();
        check("bp6_valid", 32'(out_valid), 32'd0);

        // Flush with primary and skid both full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h00100093;
        in_pc     = 32'h0000_0300;
        tick();
        in_pc = 32'h0000_0304;
        tick();
        check("fl_full_ready", 32'(in_ready), 32'd0);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        issue(32'h00700093, 32'h0000_0308);
        check("fl_next_valid", 32'(out_valid), 32'd1);
        check("fl_next_pc",    out_pc, 32'h0000_0308);
        check("fl_next_imm",   out_imm, 32'h0000_0007);
        tick();

        // Instruction offered during a flush cycle is swallowed
        flush = 1'b1;
        issue(32'h00900093, 32'h0000_0400);
        flush = 1'b0;
        check("fl_offer_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h00100093;
        in_pc     = 32'h0000_0500;
        tick();
        in_pc = 32'h0000_0504;
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd1);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        check("arst_idle", 32'(out_valid), 32'd0);
        issue(32'h00500093, 32'h0000_0600);
        check("post_valid", 32'(out_valid), 32'd1);
        check("post_imm",   out_imm, 32'h0000_0005);
        check("post_rd",    32'(out_rd), 32'd1);
        check("post_pc",    out_pc, 32'h0000_0600);
        issue(32'h00000000, 32'h0000_0604);
        check("zero_ill",   32'(out_illegal), 32'd1);
        check("zero_we",    32'(out_reg_we), 32'd0);
        check("zero_valid", 32'(out_valid), 32'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline stage between fetch and execute. Accepts a fetched instruction and its PC, decodes the RV32I base ISA, and presents registered control to the ALU: alucode, using_r2, using_pc, a sign-extended immediate, and register addresses.
- Valid/ready on both sides, with a 2-entry skid buffer so backpressure never drops an instruction.
- flush input kills wrong-path instructions.

Parameters:
- XLEN, 32, datapath width of pc, inst and imm.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all held and incoming instructions this cycle
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage can accept; equals registered !skid_valid
- in_inst  in  32  instruction word
- in_pc  in  32  instruction PC
- out_valid  out  1  decoded instruction present
- out_ready  in  1  execute accepts
- out_pc  out  32  PC of the decoded instruction
- out_imm  out  32  immediate, formatted per instruction type
- out_alucode  out  5  ALU operation code from the shared define header
- out_using_r2  out  1  1 selects r2 as ALU y; 0 selects imm
- out_using_pc  out  1  1 selects pc as ALU x; 0 selects r1
- out_rs1, out_rs2, out_rd  out  5 each  register addresses
- out_reg_we  out  1  writes rd (forced 0 when rd=0)
- out_mem_re, out_mem_we  out  1 each  load / store
- out_funct3  out  3  load/store size and branch condition
- out_is_branch, out_is_jal, out_is_jalr  out  1 each  control-flow class
- out_illegal  out  1  unsupported opcode/funct combination

Behaviour:
- Reset, asynchronous:
  - out_valid=0, skid_valid=0, in_ready=1.
  - All out_* data = 0.
  - out_alucode = ADD.
- Decode is combinational from in_inst. The result is captured into the output register (primary) or the skid register.
- Accept: in_valid && in_ready.
- Transfer: out_valid && out_ready.
- Primary empty, or being transferred this cycle:
  - If skid_valid, load from skid and clear skid.
  - Else load from the accepted instruction.
  - out_valid then reflects whether anything was loaded.
- Primary full and not transferred, with an accept: the decode goes into skid and skid_valid=1 next cycle.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 per cycle with out_ready=1.
- Output fields are stable while out_valid && !out_ready.
- flush (highest priority):
  - Next cycle out_valid=0, skid_valid=0, in_ready=1.
  - An instruction offered in the flush cycle is accepted but discarded.
- Opcode mapping (alucode, using_pc, using_r2, imm):
  - OP, 0110011: alucode per funct3/funct7 (ADD/SUB, SLL, SLT, SLTu, XOR, SRL/SRA, OR, AND), using_r2=1.
  - OP-IMM, 0010011: same ops using I-imm, using_r2=0.
    - Shifts use imm = {27'b0, inst[24:20]}.
    - funct7 other than 0000000 (or 0100000 for SRAI) -> illegal.
  - LUI: alucode LUI, imm = {inst[31:12],12'b0}.
  - AUIPC: ADD, using_pc=1, U-imm.
  - LOAD: ADD, r1+I-imm, mem_re=1, reg_we=1.
  - STORE: ADD, r1+S-imm, mem_we=1, reg_we=0.
  - BRANCH: ADD, using_pc=1, B-imm (target); is_branch=1; r2 addressed for compare; reg_we=0.
  - JAL: ADD, using_pc=1, J-imm, is_jal=1, reg_we=1.
  - JALR: ADD, r1+I-imm, is_jalr=1, reg_we=1.
- Any other opcode, or bad funct3 for LOAD/STORE/BRANCH/JALR:
  - out_illegal=1, reg_we=0, mem_re=0, mem_we=0, alucode ADD.
  - The instruction still flows; it is not dropped.
- All immediates are sign-extended from inst[31], except shift amounts.

Decomposition:
- Opcode constants, alucode constants and funct3 encodings belong in the shared define header, the same one the ALU uses.
- Natural sub-module: decode_logic, a combinational instruction-to-control-bundle decoder. It is instantiated once; the stage top holds the primary/skid registers and the handshake.

Test Plan:
- ADDI x1,x0,5 (0x00500093) with out_ready=1 -> next cycle: out_valid=1, alucode ADD, using_r2=0, using_pc=0, imm=0x00000005, rd=1, rs1=0, reg_we=1.
- SRAI x2,x1,3 (0x4030D113) -> alucode SRA, imm=0x00000003, illegal=0. Same word with inst[30]=0 and inst[29]=1 (0x2030D113) -> illegal=1, reg_we=0.
- LUI x5,0x12345 (0x123452B7) -> alucode LUI, imm=0x12345000. BEQ x1,x2,-4 (0xFE208EE3) at pc=0x100 -> ADD, using_pc=1, imm=0xFFFFFFFC, is_branch=1, rs1=1, rs2=2, reg_we=0.
- Backpressure: stream 3 instructions at 1/cycle, with out_ready=0 from the first output.
  - Second lands in skid, then in_ready=0; the third is held by fetch.
  - After raising out_ready, all three emerge in order; no loss or duplication.
- Flush while primary and skid are both full -> next cycle out_valid=0, in_ready=1. The next accepted instruction appears with its own pc.
- Assert rst_n low mid-stream -> out_valid=0 and in_ready=1 immediately (asynchronous). The first post-reset instruction decodes correctly. 0x00000000 -> illegal=1.
